nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl.sv | 79 +++++++
 tb/tb_nibble_serial_add_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two W-bit operands one nibble per cycle on a shared external 4-bit adder
// Ports: clk/rst_n (async active-low); in_valid/in_ready accept A, B, Cin;
//   add_A/add_B/add_Cin drive the shared adder, add_Sum/add_Cout are its same-cycle results;
//   Sum/Cout hold the registered result, offered with out_valid/out_ready.
// Optional macro NIBBLE_SUB_EN adds input Op (1 = A-B, Cout=1 means no borrow).
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 Cin,
`ifdef NIBBLE_SUB_EN
  input  logic                 Op,
`endif
  output logic [3:0]           add_A,
  output logic [3:0]           add_B,
  output logic                 add_Cin,
  input  logic [3:0]           add_Sum,
  input  logic                 add_Cout,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 Cout,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int W = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [W-1:0] a_reg, b_reg;
  logic [IW-1:0] idx;
  logic carry, sub, op_in, run;
`ifdef NIBBLE_SUB_EN
  assign op_in = Op;
`else
  assign op_in = 1'b0;
`endif
  assign run = state == RUN;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // subtraction is A + ~B + 1: invert the B nibble, carry seeded with 1 at accept
  always_comb begin
    add_A = run ? a_reg[4*idx +: 4] : 4'd0;
    add_B = run ? b_reg[4*idx +: 4] ^ {4{sub}} : 4'd0;
    add_Cin = run & carry;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx <= '0;
      carry <= 1'b0;
      sub <= 1'b0;
      Sum <= '0;
      Cout <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_reg <= A;
      b_reg <= B;
      sub <= op_in;
      idx <= '0;
      carry <= op_in | Cin;
      state <= RUN;
    end else if (run) begin
      Sum[4*idx +: 4] <= add_Sum;
      carry <= add_Cout;
      idx <= idx + 1'b1;
      if (idx == IW'(NIBBLES - 1)) begin
        Cout <= add_Cout;
        state <= DONE;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: randomized and directed checks of the nibble-serial adder against a behavioural model
module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
`ifdef NIBBLE_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, Cin = 0, op = 0;
  logic [15:0] A = 0, B = 0, Sum;
  logic [3:0] add_A, add_B, add_Sum;
  logic add_Cin, add_Cout, in_ready, out_valid, Cout;
  int total = 0, bad = 0;
  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
`ifdef NIBBLE_SUB_EN
    .Op(op),
`endif
    .add_A(add_A), .add_B(add_B), .add_Cin(add_Cin),
    .add_Sum(add_Sum), .add_Cout(add_Cout),
    .Sum(Sum), .Cout(Cout), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  // the shared external adder
  always_comb {add_Cout, add_Sum} = 5'(add_A) + 5'(add_B) + 5'(add_Cin);
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // model: idle / computing for k cycles / holding result; results from plain arithmetic
  int mst = 0, k = 0;
  logic [15:0] ma, mb, m_sum, last_sum = 0, lm;
  logic mc, m_cout, last_cout = 0;
  logic [16:0] t;
  logic [15:0] run_a;
  logic [3:0] run_c;
  always @(negedge clk) begin
    if (!rst_n) begin
      mst = 0;
      last_sum = 0;
      last_cout = 0;
      chk("rst_sum", Sum, 0);
      chk("rst_cout", Cout, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_add", {add_A, add_B, add_Cin}, 0);
    end else begin
      chk("in_ready", in_ready, mst == 0);
      chk("out_valid", out_valid, mst == 2);
      if (mst == 1) begin
        lm = (k == 0) ? 16'h0 : 16'hFFFF >> (16 - 4 * k);
        t = 17'(ma & lm) + 17'(mb & lm) + 17'(mc);
        chk("add_A", add_A, (ma >> (4 * k)) & 16'hF);
        chk("add_B", add_B, (mb >> (4 * k)) & 16'hF);
        chk("add_Cin", add_Cin, (t >> (4 * k)) & 17'h1);
        chk("sum_partial", Sum, (m_sum & lm) | (last_sum & ~lm));
        chk("cout_run", Cout, last_cout);
        run_a = {run_a[11:0], add_A};
        run_c = {run_c[2:0], add_Cin};
        k++;
        if (k == N) mst = 2;
      end else begin
        chk("add_idle", {add_A, add_B, add_Cin}, 0);
        chk("sum_hold", Sum, mst == 2 ? m_sum : last_sum);
        chk("cout_hold", Cout, mst == 2 ? m_cout : last_cout);
        if (mst == 0 && in_valid) begin
          ma = A;
          mb = (SUB && op) ? ~B : B;
          mc = (SUB && op) ? 1'b1 : Cin;
          {m_cout, m_sum} = 17'(ma) + 17'(mb) + 17'(mc);
          k = 0;
          mst = 1;
          run_a = 0;
          run_c = 0;
        end else if (mst == 2 && out_ready) begin
          last_sum = m_sum;
          last_cout = m_cout;
          mst = 0;
        end
      end
    end
  end
  task automatic do_op(input logic [15:0] a, b, input logic c, o, input int hold, input bit noise,
                       output logic [15:0] rs, output logic rc, output int lat);
    @(posedge clk); #1;
    A = a; B = b; Cin = c; op = o; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); op = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (noise) in_valid = 1'($urandom);
    end
    if (lat >= 20) chk("timeout_out_valid", 0, 1);
    rs = Sum;
    rc = Cout;
    repeat (hold) begin
      @(posedge clk); #1;
      if (noise) in_valid = 1'($urandom);
      chk("done_sum_stable", Sum, rs);
      chk("done_cout_stable", Cout, rc);
      chk("done_out_valid", out_valid, 1);
      chk("done_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_after_hs", in_ready, 1);
    chk("no_valid_after_hs", out_valid, 0);
  endtask
  logic [15:0] rs;
  logic rc;
  int lat;
  initial begin
    #1;
    chk("init_in_ready", in_ready, 1);
    chk("init_out_valid", out_valid, 0);
    chk("init_sum", Sum, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    do_op(16'h0001, 16'h0002, 0, 0, 0, 0, rs, rc, lat);
    chk("r26_sum", rs, 16'h0003);
    chk("r26_cout", rc, 0);
    chk("r26_latency", lat, 4);
    do_op(16'hFFFF, 16'h0001, 0, 0, 0, 0, rs, rc, lat);
    chk("r27_sum", rs, 16'h0000);
    chk("r27_cout", rc, 1);
    chk("r27_carry_seq", run_c, 4'b0111);
    do_op(16'h1234, 16'h4321, 1, 0, 0, 0, rs, rc, lat);
    chk("r28_sum", rs, 16'h5556);
    chk("r28_cout", rc, 0);
    chk("r28_add_A_seq", run_a, 16'h4321);
    do_op(16'hABCD, 16'h1111, 0, 0, 3, 1, rs, rc, lat);
    chk("r29_sum", rs, 16'hBCDE);
    chk("r29_cout", rc, 0);
    chk("r29_sum_kept_idle", Sum, 16'hBCDE);
    @(posedge clk); #1;
    A = 16'h1111; B = 16'h1111; Cin = 0; op = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("r30_sum", Sum, 0);
    chk("r30_cout", Cout, 0);
    chk("r30_out_valid", out_valid, 0);
    chk("r30_in_ready", in_ready, 1);
    chk("r30_add", {add_A, add_B, add_Cin}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    do_op(16'h000F, 16'h0001, 0, 0, 0, 0, rs, rc, lat);
    chk("r30_next_sum", rs, 16'h0010);
    chk("r30_next_cout", rc, 0);
`ifdef NIBBLE_SUB_EN
    do_op(16'h0005, 16'h0007, 0, 1, 0, 0, rs, rc, lat);
    chk("r31_sum_a", rs, 16'hFFFE);
    chk("r31_cout_a", rc, 0);
    do_op(16'h0007, 16'h0005, 0, 1, 0, 0, rs, rc, lat);
    chk("r31_sum_b", rs, 16'h0002);
    chk("r31_cout_b", rc, 1);
`endif
    for (int i = 0; i < 150; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1, rs, rc, lat);
      chk("rand_latency", lat, 4);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
